switch_debounce: RTL and testbench



---
 rtl/switch_debounce.sv | 72 +++++++
 tb/tb_switch_debounce.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/switch_debounce.sv
// switch_debounce: synchronizes and debounces a switch vector, committing only patterns held stable.
// Optional SWITCH_DEBOUNCE_PATTERN_FILTER_EN restricts commits to one-hot / one-cold patterns.
module switch_debounce #(
    parameter int                WIDTH           = 5,
    parameter int                SYNC_STAGES     = 2,
    parameter int                DEBOUNCE_CYCLES = 50000,
    parameter logic [WIDTH-1:0]  RESET_VALUE     = '0
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] switch_in,
    output logic [WIDTH-1:0] config_out,
    output logic             config_valid,
    output logic             config_strobe
);
    localparam int            CW  = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] SAT = CW'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [WIDTH-1:0] sync, cand_q, cand_d, out_q, out_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             valid_q, valid_d, strobe_q, strobe_d, pat_ok;

    assign sync = sync_q[SYNC_STAGES-1];

`ifdef SWITCH_DEBOUNCE_PATTERN_FILTER_EN
    assign pat_ok = ($countones(cand_q) == 1) || ($countones(~cand_q) == 1);
`else
    assign pat_ok = 1'b1;
`endif

    // Any change restarts the count; a saturated count commits once per new pattern.
    always_comb begin
        cand_d   = cand_q;
        cnt_d    = cnt_q;
        out_d    = out_q;
        valid_d  = valid_q;
        strobe_d = 1'b0;
        if (sync != cand_q) begin
            cand_d = sync;
            cnt_d  = '0;
        end else if (cnt_q != SAT) begin
            cnt_d = cnt_q + 1'b1;
        end else if (pat_ok && ((cand_q != out_q) || !valid_q)) begin
            out_d    = cand_q;
            valid_d  = 1'b1;
            strobe_d = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            sync_q   <= {SYNC_STAGES{RESET_VALUE}};
            cand_q   <= RESET_VALUE;
            cnt_q    <= '0;
            out_q    <= RESET_VALUE;
            valid_q  <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], switch_in};
            cand_q   <= cand_d;
            cnt_q    <= cnt_d;
            out_q    <= out_d;
            valid_q  <= valid_d;
            strobe_q <= strobe_d;
        end
    end

    assign config_out    = out_q;
    assign config_valid  = valid_q;
    assign config_strobe = strobe_q;
endmodule

// File: tb/tb_switch_debounce.sv
// tb_switch_debounce: directed scoreboard bench for switch_debounce with DEBOUNCE_CYCLES=4.
module tb_switch_debounce;
    logic       clock = 1'b0;
    logic       reset_n;
    logic [4:0] switch_in;
    logic [4:0] config_out;
    logic       config_valid, config_strobe;

    typedef struct {
        int         edge_no;
        logic [4:0] out;
        logic       valid;
        logic       strobe;
    } exp_t;

    exp_t sb[$];
    int   ecount = 0;
    int   base = 0;
    int   compared = 0;
    int   mismatched = 0;

    switch_debounce #(.DEBOUNCE_CYCLES(4)) dut (
        .clock(clock), .reset_n(reset_n), .switch_in(switch_in),
        .config_out(config_out), .config_valid(config_valid), .config_strobe(config_strobe)
    );

    always #5 clock = ~clock;
    always @(posedge clock) ecount <= ecount + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1);
    end

    task automatic push(input int rel, input logic [4:0] o, input logic v, input logic s);
        exp_t e;
        e.edge_no = base + rel;
        e.out = o;
        e.valid = v;
        e.strobe = s;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            @(negedge clock);
            while (sb.size() > 0 && sb[0].edge_no <= ecount) begin
                e = sb.pop_front();
                compared++;
                assert ({config_out, config_valid, config_strobe} === {e.out, e.valid, e.strobe})
                else begin
                    mismatched++;
                    $error("FAIL edge%0d got out/valid/strobe=%b/%b/%b expected %b/%b/%b",
                           e.edge_no, config_out, config_valid, config_strobe, e.out, e.valid, e.strobe);
                end
            end
        end
        #1;
    endtask

    // Expected trace for 10 edges after a step: commit (if any) lands on edge 7.
    task automatic settle(input logic [4:0] old_o, input logic old_v, input logic [4:0] new_o, input logic commit);
        base = ecount;
        for (int r = 1; r <= 10; r++) begin
            if (r < 7 || !commit) push(r, old_o, old_v, 1'b0);
            else push(r, new_o, 1'b1, r == 7);
        end
        tick(10);
    endtask

    task automatic check_now(input string tag, input logic [6:0] exp_v);
        compared++;
        assert ({config_out, config_valid, config_strobe} === exp_v)
        else begin
            mismatched++;
            $error("FAIL %s got %b expected %b", tag, {config_out, config_valid, config_strobe}, exp_v);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        switch_in = 5'b00000;
        tick(3);
        check_now("reset", 7'b0000000);
        // Held input equals the reset value: sync and candidate already match, so commit at edge 4.
        reset_n = 1'b1;
        base = ecount;
        for (int r = 1; r <= 10; r++) begin
            if (r < 4) push(r, 5'b00000, 1'b0, 1'b0);
            else push(r, 5'b00000, 1'b1, r == 4);
        end
        tick(10);

        switch_in = 5'b00100;
        settle(5'b00000, 1'b1, 5'b00100, 1'b1);

        for (int i = 0; i < 39; i++) begin
            switch_in = ((i / 3) % 2) ? 5'b00010 : 5'b00001;
            base = ecount;
            push(1, 5'b00100, 1'b1, 1'b0);
            tick(1);
        end
        switch_in = 5'b00010;
        settle(5'b00100, 1'b1, 5'b00010, 1'b1);

        switch_in = 5'b01000;
        settle(5'b00010, 1'b1, 5'b01000, 1'b1);
        switch_in = 5'b00000;
        base = ecount;
        push(1, 5'b01000, 1'b1, 1'b0);
        push(2, 5'b01000, 1'b1, 1'b0);
        tick(2);
        switch_in = 5'b01000;
        settle(5'b01000, 1'b1, 5'b01000, 1'b0);

        switch_in = 5'b10000;
        base = ecount;
        for (int r = 1; r <= 4; r++) push(r, 5'b01000, 1'b1, 1'b0);
        tick(4);
        #2;
        reset_n = 1'b0;
        #1;
        check_now("async_reset", 7'b0000000);
        tick(2);
        check_now("in_reset", 7'b0000000);
        reset_n = 1'b1;
        settle(5'b00000, 1'b0, 5'b10000, 1'b1);

        switch_in = 5'b00011;
`ifdef SWITCH_DEBOUNCE_PATTERN_FILTER_EN
        base = ecount;
        for (int r = 1; r <= 20; r++) push(r, 5'b10000, 1'b1, 1'b0);
        tick(20);
        switch_in = 5'b11101;
        settle(5'b10000, 1'b1, 5'b11101, 1'b1);
`else
        settle(5'b10000, 1'b1, 5'b00011, 1'b1);
        base = ecount;
        for (int r = 1; r <= 10; r++) push(r, 5'b00011, 1'b1, 1'b0);
        tick(10);
        switch_in = 5'b11101;
        settle(5'b00011, 1'b1, 5'b11101, 1'b1);
`endif

        tick(2);
        compared++;
        assert (sb.size() == 0)
        else begin
            mismatched++;
            $error("FAIL scoreboard_drain got %0d entries expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
